idli_ctl_m: RTL and testbench

IDLI_CTL_M -- requirements
Module: idli_ctl_m

---
 rtl/idli_ctl_m.sv | 111 +++++++++++
 tb/tb_idli_ctl_m.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/idli_ctl_m.sv
// rtl/idli_ctl_m.sv - beat-sequenced core control FSM for the idli bit-serial core
// A 2-bit slice counter defines four-cycle beats; the FSM moves only at beat ends.
module idli_ctl_m #(
   parameter int unsigned TIMEOUT_BEATS = 16
) (
   input  logic       i_ctl_gck,
   input  logic       i_ctl_rst_n,
   input  logic       i_ctl_instr_vld,
   input  logic       i_ctl_redirect,
   input  logic       i_ctl_mem_rd,
   input  logic       i_ctl_mem_wr,
   input  logic       i_ctl_mem_done,
   output logic [1:0] o_ctl_ctr,
   output logic [2:0] o_ctl_state,
   output logic       o_ctl_ex_en,
   output logic       o_ctl_sqi_redirect,
   output logic       o_ctl_sqi_data_en,
   output logic       o_ctl_sqi_wr_en,
   output logic       o_ctl_err
);

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_FLUSH   = 3'd1,
      ST_FETCH   = 3'd2,
      ST_EXEC    = 3'd3,
      ST_DATA_RD = 3'd4,
      ST_DATA_WR = 3'd5
   } state_t;

   localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_BEATS);

   state_t     state_q, state_d;
   logic [1:0] ctr_q, ctr_d;
   logic [7:0] beat_q, beat_d;
   logic       err_q, err_d;
   logic       beat_end;

   assign beat_end = (ctr_q == 2'd3);

   always_ff @(posedge i_ctl_gck or negedge i_ctl_rst_n) begin
      if (!i_ctl_rst_n) begin
         state_q <= ST_INIT;
         ctr_q   <= 2'd0;
         beat_q  <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

   // Inputs are only looked at on the last slice of a beat.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      err_d   = err_q;
      ctr_d   = ctr_q + 2'd1;
      if (beat_end) begin
         case (state_q)
            ST_INIT: begin
               if (beat_q == 8'd1) begin
                  state_d = ST_FLUSH;
                  beat_d  = 8'd0;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
            ST_FLUSH: state_d = ST_FETCH;
            ST_FETCH: begin
               if (i_ctl_instr_vld) state_d = ST_EXEC;
            end
            ST_EXEC: begin
               beat_d = 8'd0;
               if (i_ctl_redirect)    state_d = ST_FLUSH;
               else if (i_ctl_mem_rd) state_d = ST_DATA_RD;
               else if (i_ctl_mem_wr) state_d = ST_DATA_WR;
               else                   state_d = ST_FETCH;
            end
            ST_DATA_RD, ST_DATA_WR: begin
               // Completion beats the timeout when both land on the same beat.
               if (i_ctl_mem_done) begin
                  state_d = ST_FETCH;
                  beat_d  = 8'd0;
               end else if (({1'b0, beat_q} + 9'd1) >= TIMEOUT_LIM) begin
                  state_d = ST_FLUSH;
                  beat_d  = 8'd0;
                  err_d   = 1'b1;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
            default: begin
               state_d = ST_FLUSH;
               beat_d  = 8'd0;
            end
         endcase
      end
   end

   assign o_ctl_ctr          = ctr_q;
   assign o_ctl_state        = state_q;
   assign o_ctl_err          = err_q;
   assign o_ctl_ex_en        = (state_q == ST_EXEC);
   assign o_ctl_sqi_redirect = (state_q == ST_FLUSH);
   assign o_ctl_sqi_data_en  = (state_q == ST_DATA_RD) || (state_q == ST_DATA_WR);
   assign o_ctl_sqi_wr_en    = (state_q == ST_DATA_WR);

endmodule

// File: tb/tb_idli_ctl_m.sv
// tb/tb_idli_ctl_m.sv - self-checking bench for idli_ctl_m against a beat-level model
module tb_idli_ctl_m;
   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vld = 1'b0, redir = 1'b0, rd = 1'b0, wr = 1'b0, done = 1'b0;
   logic [1:0] o_ctr;
   logic [2:0] o_state;
   logic       o_ex_en, o_redir, o_data_en, o_wr_en, o_err;

   int total = 0;
   int bad = 0;

   // Model: state code, beats spent in it, sticky error.
   int m_state, m_age, m_err;

   idli_ctl_m #(.TIMEOUT_BEATS(TO)) dut (
      .i_ctl_gck          (clk),
      .i_ctl_rst_n        (rst_n),
      .i_ctl_instr_vld    (vld),
      .i_ctl_redirect     (redir),
      .i_ctl_mem_rd       (rd),
      .i_ctl_mem_wr       (wr),
      .i_ctl_mem_done     (done),
      .o_ctl_ctr          (o_ctr),
      .o_ctl_state        (o_state),
      .o_ctl_ex_en        (o_ex_en),
      .o_ctl_sqi_redirect (o_redir),
      .o_ctl_sqi_data_en  (o_data_en),
      .o_ctl_sqi_wr_en    (o_wr_en),
      .o_ctl_err          (o_err)
   );

   always #5 clk = ~clk;

   // {ex_en, sqi_redirect, sqi_data_en, sqi_wr_en} expected for a state code.
   function automatic logic [3:0] exp_dec(input int s);
      exp_dec = {s == 3, s == 1, (s == 4) || (s == 5), s == 5};
   endfunction

   function automatic logic [3:0] obs_dec();
      obs_dec = {o_ex_en, o_redir, o_data_en, o_wr_en};
   endfunction

   task automatic model_reset();
      m_state = 0; m_age = 0; m_err = 0;
   endtask

   task automatic model_go(input int s);
      m_state = s; m_age = 0;
   endtask

   // Beat-end transition rules: in = {vld, redirect, rd, wr, done}.
   task automatic model_beat(input logic [4:0] in);
      case (m_state)
         0: if (m_age == 1) model_go(1); else m_age++;
         1: model_go(2);
         2: if (in[4]) model_go(3);
         3: begin
            if (in[3])      model_go(1);
            else if (in[2]) model_go(4);
            else if (in[1]) model_go(5);
            else            model_go(2);
         end
         default: begin
            if (in[0]) model_go(2);
            else if (m_age + 1 >= TO) begin model_go(1); m_err = 1; end
            else m_age++;
         end
      endcase
   endtask

   // Entered at 1ns after a rising edge with ctr expected 0. Real inputs appear
   // only on slice 3; other slices carry junk (random, or all ones).
   task automatic run_beat(input logic [4:0] in, input bit junk_ones,
                           output logic [2:0] st, output logic [3:0] dec,
                           output logic er, output bit stable);
      stable = 1'b1;
      for (int c = 0; c < 4; c++) begin
         logic [4:0] j;
         j = junk_ones ? 5'h1f : 5'($urandom);
         {vld, redir, rd, wr, done} = (c == 3) ? in : j;
         #2;
         if (c == 0) begin
            st = o_state; dec = obs_dec(); er = o_err;
         end else if (o_state !== st || obs_dec() !== dec || o_err !== er) begin
            stable = 1'b0;
         end
         if (o_ctr !== 2'(c)) stable = 1'b0;
         @(posedge clk); #1;
      end
      {vld, redir, rd, wr, done} = 5'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #13;
      total++;
      if ({o_ctr, o_state, obs_dec(), o_err} !== 10'b0) begin
         bad++;
         $display("FAIL reset_state: got ctr=%0d st=%0d dec=%b err=%b, want all 0",
                  o_ctr, o_state, obs_dec(), o_err);
      end
      do_reset();
   endtask

   // Runs a stimulus list, comparing each beat's outputs with the model first.
   task automatic run_list(input logic [4:0] seq[$], input int tag);
      logic [2:0] st; logic [3:0] dec; logic er; bit stable;
      foreach (seq[i]) begin
         run_beat(seq[i], (i % 3) == 1, st, dec, er, stable);
         total++;
         if ({st, dec, er, stable} !== {3'(m_state), exp_dec(m_state), 1'(m_err), 1'b1}) begin
            bad++;
            $display("FAIL seq%0d beat%0d: got st=%0d dec=%b err=%b stable=%b, want st=%0d dec=%b err=%0d stable=1",
                     tag, i, st, dec, er, stable, m_state, exp_dec(m_state), m_err);
         end
         model_beat(seq[i]);
      end
   endtask

   task automatic test_init_flush();
      run_list('{5'b0, 5'b0, 5'b0, 5'b0, 5'b0}, 1);
   endtask

   task automatic test_fetch_pulse();
      run_list('{5'b0, 5'b0, 5'b10000, 5'b0, 5'b0}, 2);
   endtask

   task automatic test_exec_priority();
      run_list('{5'b10000, 5'b01110, 5'b0, 5'b0, 5'b10000, 5'b00110, 5'b0, 5'b00001, 5'b0}, 3);
   endtask

   task automatic test_data_wr_done();
      run_list('{5'b10000, 5'b00010, 5'b0, 5'b0, 5'b00001, 5'b0}, 4);
   endtask

   task automatic test_done_vs_timeout();
      run_list('{5'b10000, 5'b00100, 5'b0, 5'b0, 5'b0, 5'b00001, 5'b0}, 5);
   endtask

   task automatic test_timeout();
      run_list('{5'b10000, 5'b00100, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0,
                 5'b10000, 5'b00010, 5'b00001, 5'b0, 5'b0}, 6);
   endtask

   task automatic test_random();
      logic [4:0] seq[$];
      for (int i = 0; i < 150; i++) begin
         logic [4:0] v;
         v = 5'($urandom);
         v[0] = ($urandom_range(0, 3) == 0);
         seq.push_back(v);
      end
      run_list(seq, 7);
   endtask

   task automatic test_reset_mid();
      run_list('{5'b10000, 5'b00010, 5'b0}, 8);
      repeat (2) @(posedge clk);
      #3;
      total++;
      if ({o_ctr, o_state, o_wr_en} !== {2'd2, 3'd5, 1'b1}) begin
         bad++;
         $display("FAIL pre_reset_wr: got ctr=%0d st=%0d wr_en=%b, want ctr=2 st=5 wr_en=1",
                  o_ctr, o_state, o_wr_en);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({o_ctr, o_state, obs_dec(), o_err} !== 10'b0) begin
         bad++;
         $display("FAIL async_reset: got ctr=%0d st=%0d dec=%b err=%b, want all 0",
                  o_ctr, o_state, obs_dec(), o_err);
      end
      @(posedge clk); #1;
      do_reset();
      run_list('{5'b0, 5'b0, 5'b0, 5'b0, 5'b10000, 5'b0}, 9);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_init_flush();
      test_fetch_pulse();
      test_exec_priority();
      test_data_wr_done();
      test_done_vs_timeout();
      test_timeout();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
